// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared op codes and FSM state encoding for the bitwise logic unit
package logic_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_NAND  = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_ANDN  = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bitwise_slice.sv
// rtl/bitwise_slice.sv - combinational CHUNK-bit slice applying one of eight bitwise functions
module bitwise_slice
  import logic_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [CHUNK-1:0] y_o
);

  // One independent cell per bit; the op select fans out to every cell.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic y_bit;

    // Per-bit function select.
    always_comb begin
      y_bit = 1'b0;
      case (op_i)
        OP_AND:   y_bit =   a_i[i] &  b_i[i];
        OP_OR:    y_bit =   a_i[i] |  b_i[i];
        OP_XOR:   y_bit =   a_i[i] ^  b_i[i];
        OP_NOR:   y_bit = ~(a_i[i] |  b_i[i]);
        OP_NAND:  y_bit = ~(a_i[i] &  b_i[i]);
        OP_XNOR:  y_bit = ~(a_i[i] ^  b_i[i]);
        OP_ANDN:  y_bit =   a_i[i] & ~b_i[i];
        OP_PASSA: y_bit =   a_i[i];
        default:  y_bit = 1'b0;
      endcase
    end

    assign y_o[i] = y_bit;
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - multi-cycle, CHUNK-per-cycle bitwise logic unit with zero/parity flags
module bitwise_logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity
);

  localparam int NSLICE = WIDTH / CHUNK;
  // Counter is kept at least one bit wide even when a single slice covers the word.
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("bitwise_logic_unit: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              parity_q, parity_d;
  logic              zero_q, zero_d;

  logic [CHUNK-1:0]  a_cur, b_cur, y_cur;
  logic              last_slice;

  // Select the operand slices addressed by the counter.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (cnt_q == CW'(s)) begin
        a_cur = a_q[s*CHUNK +: CHUNK];
        b_cur = b_q[s*CHUNK +: CHUNK];
      end
    end
  end

  bitwise_slice #(.CHUNK(CHUNK)) u_slice (
    .a_i  (a_cur),
    .b_i  (b_cur),
    .op_i (op_q),
    .y_o  (y_cur)
  );

  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  // Next-state, operand latch, slice write-back and flag accumulation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    parity_d = parity_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          op_d     = in_op;
          cnt_d    = '0;
          result_d = '0;
          parity_d = 1'b0;
          zero_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int s = 0; s < NSLICE; s++) begin
          if (cnt_q == CW'(s)) begin
            result_d[s*CHUNK +: CHUNK] = y_cur;
          end
        end
        parity_d = parity_q ^ (^y_cur);
        zero_d   = zero_q & (y_cur == '0);
        if (last_slice) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; synchronous reset aborts any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      result_q <= '0;
      parity_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      parity_q <= parity_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_parity = parity_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - directed self-checking bench for bitwise_logic_unit
module tb_bitwise_logic_unit;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_parity;

  logic        in_valid1, in_ready1;
  logic [31:0] in_a1, in_b1;
  logic [2:0]  in_op1;
  logic        out_valid1, out_ready1;
  logic [31:0] out_result1;
  logic        out_zero1, out_parity1;

  int n_cmp = 0;
  int n_bad = 0;

  bitwise_logic_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity)
  );

  bitwise_logic_unit #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .in_a       (in_a1),
    .in_b       (in_b1),
    .in_op      (in_op1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .out_result (out_result1),
    .out_zero   (out_zero1),
    .out_parity (out_parity1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the CHUNK=8 unit, check latency, result and flags, then drain it.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_par);
    int n;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = ~a; in_b = 32'h1234_5678; in_op = op + 3'd3;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 32'd5);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
    check({tag, "_parity"}, {31'd0, out_parity}, {31'd0, exp_par});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    int n;
    sweep_exp = '{32'hA5A50000, 32'hFFFFA5A5, 32'h5A5AA5A5, 32'h00005A5A,
                  32'h5A5AFFFF, 32'hA5A55A5A, 32'h0000A5A5, 32'hA5A5A5A5};

    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_op1 = '0; out_ready1 = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst_in_ready",  {31'd0, in_ready},   32'd1);
    check("rst_out_valid", {31'd0, out_valid},  32'd0);
    check("rst_result",    out_result,          32'd0);
    check("rst_zero",      {31'd0, out_zero},   32'd1);
    check("rst_parity",    {31'd0, out_parity}, 32'd0);

    run_op("xor1", 32'hFFFF0000, 32'h0F0F0F0F, 3'd2, 32'hF0F00F0F, 1'b0, 1'b0);
    run_op("xor_eq", 32'hDEADBEEF, 32'hDEADBEEF, 3'd2, 32'h00000000, 1'b1, 1'b0);
    run_op("and13", 32'h00000001, 32'h00000003, 3'd0, 32'h00000001, 1'b0, 1'b1);

    for (int op = 0; op < 8; op++) begin
      run_op($sformatf("sweep%0d", op), 32'hA5A5A5A5, 32'hFFFF0000, 3'(op),
             sweep_exp[op], (sweep_exp[op] == 32'd0), ^sweep_exp[op]);
    end

    // Backpressure: stall in DONE with a competing request on the input.
    in_a = 32'hFFFF0000; in_b = 32'h0F0F0F0F; in_op = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_latency", n, 32'd5);
    in_a = 32'h11111111; in_b = 32'h22222222; in_op = 3'd1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp_valid%0d", c),  {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_ready%0d", c),  {31'd0, in_ready},  32'd0);
      check($sformatf("bp_result%0d", c), out_result,         32'hF0F00F0F);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_in_ready",  {31'd0, in_ready},  32'd1);
    check("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_rel_result",    out_result,         32'hF0F00F0F);

    // Reset in the second RUN cycle; in_valid held high is ignored during reset.
    in_a = 32'hFFFFFFFF; in_b = 32'h0; in_op = 3'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("rr_in_ready",  {31'd0, in_ready},   32'd1);
    check("rr_out_valid", {31'd0, out_valid},  32'd0);
    check("rr_result",    out_result,          32'd0);
    check("rr_zero",      {31'd0, out_zero},   32'd1);
    check("rr_parity",    {31'd0, out_parity}, 32'd0);
    run_op("after_rst", 32'h12345678, 32'h0000FFFF, 3'd6, 32'h12340000, 1'b0, 1'b1);

    // Single-slice configuration.
    in_a1 = 32'hFFFF0000; in_b1 = 32'h0F0F0F0F; in_op1 = 3'd2; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    n = 1;
    while (!out_valid1 && n < 20) begin
      tick();
      n++;
    end
    check("c32_latency", n, 32'd2);
    check("c32_result", out_result1, 32'hF0F00F0F);
    check("c32_zero",   {31'd0, out_zero1},   32'd0);
    check("c32_parity", {31'd0, out_parity1}, 32'd0);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("c32_idle", {31'd0, in_ready1}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
